// File: rtl/membus_avl_master.sv
`default_nettype none
// ============================================================================
// Module      : membus_avl_master
// Description : Avalon-MM register window that runs single PDP-10 memory-bus
//               read/write cycles on one memory slave port, with an NXM
//               watchdog and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module membus_avl_master #(
   parameter int TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  s_address,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   input  logic        s_read,
   output logic [31:0] s_readdata,
   output logic        irq,
   output logic        membus_rq_cyc,
   output logic        membus_rd_rq,
   output logic        membus_wr_rq,
   output logic        membus_wr_rs,
   output logic [14:0] membus_ma,
   output logic [3:0]  membus_sel,
   output logic        membus_fmc_select,
   output logic [35:0] membus_mb_write,
   input  logic        membus_addr_ack,
   input  logic        membus_rd_rs,
   input  logic [35:0] membus_mb_read
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_REQ  = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_WR_REQ  = 3'd3;
   localparam logic [2:0] S_WR_RS   = 3'd4;
   localparam logic [2:0] S_FIN     = 3'd5;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [14:0]   ma_q;
   logic [3:0]    sel_q;
   logic          fmc_q;
   logic [17:0]   lh_q;
   logic [17:0]   rh_q;
   logic          ie_q;
   logic          done_q;
   logic          err_q;
   logic [CW-1:0] wdog;
   logic [31:0]   readdata_q;

   logic busy;
   logic timeout_hit;
   logic csr_wr;
   logic go_rd;
   logic go_wr;
   logic go_accept;
   logic start_rd;
   logic start_wr;
   logic rd_capture;
   logic unused_wdata;

   // Upper write-data bits have no register behind them
   assign unused_wdata = ^s_writedata[31:20];

   // FIN is not busy: software may already see the result and issue a new GO
   assign busy        = (state != S_IDLE) && (state != S_FIN);
   // The edge on which the counter would reach TIMEOUT aborts the cycle
   assign timeout_hit = busy && (wdog == CW'(TIMEOUT - 1));
   assign csr_wr      = s_write && (s_address == 2'd3);
   assign go_rd       = s_writedata[0];
   assign go_wr       = s_writedata[1];
   assign go_accept   = csr_wr && !busy && (go_rd || go_wr);
   assign start_rd    = go_accept && go_rd && !go_wr;
   assign start_wr    = go_accept && go_wr && !go_rd;
   // An abort on the same edge wins over late read data
   assign rd_capture  = !timeout_hit &&
                        (((state == S_RD_REQ) && membus_addr_ack && membus_rd_rs) ||
                         ((state == S_RD_WAIT) && membus_rd_rs));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; the watchdog overrides every transition
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start_rd)      state_nxt = S_RD_REQ;
            else if (start_wr) state_nxt = S_WR_REQ;
         end
         S_RD_REQ: begin
            if (membus_addr_ack) state_nxt = membus_rd_rs ? S_FIN : S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (membus_rd_rs) state_nxt = S_FIN;
         end
         S_WR_REQ: begin
            if (membus_addr_ack) state_nxt = S_WR_RS;
         end
         S_WR_RS: state_nxt = S_FIN;
         S_FIN: begin
            if (start_rd)      state_nxt = S_RD_REQ;
            else if (start_wr) state_nxt = S_WR_REQ;
            else               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (timeout_hit) state_nxt = S_IDLE;
   end

   // Bus request strobes decoded from the current state
   always_comb begin
      membus_rq_cyc = 1'b0;
      membus_rd_rq  = 1'b0;
      membus_wr_rq  = 1'b0;
      membus_wr_rs  = 1'b0;
      case (state)
         S_RD_REQ: begin
            membus_rq_cyc = 1'b1;
            membus_rd_rq  = 1'b1;
         end
         S_RD_WAIT: membus_rd_rq = 1'b1;
         S_WR_REQ: begin
            membus_rq_cyc = 1'b1;
            membus_wr_rq  = 1'b1;
         end
         S_WR_RS: begin
            membus_wr_rq = 1'b1;
            membus_wr_rs = 1'b1;
         end
         default: ;
      endcase
   end

   // Watchdog: restarts with each new cycle, counts while a cycle is open
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 wdog <= '0;
      else if (start_rd || start_wr) wdog <= '0;
      else if (busy)                wdog <= wdog + CW'(1);
   end

   // ADDR and DATA registers; frozen while a bus cycle is open
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ma_q  <= '0;
         sel_q <= '0;
         fmc_q <= 1'b0;
         lh_q  <= '0;
         rh_q  <= '0;
      end else if (rd_capture) begin
         lh_q <= membus_mb_read[35:18];
         rh_q <= membus_mb_read[17:0];
      end else if (s_write && !busy) begin
         case (s_address)
            2'd0: begin
               ma_q  <= s_writedata[14:0];
               sel_q <= s_writedata[18:15];
               fmc_q <= s_writedata[19];
            end
            2'd1:    rh_q <= s_writedata[17:0];
            2'd2:    lh_q <= s_writedata[17:0];
            default: ;
         endcase
      end
   end

   // CSR status: an accepted GO clears the previous result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ie_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (csr_wr) ie_q <= s_writedata[4];
         if (go_accept) begin
            done_q <= 1'b0;
            err_q  <= go_rd && go_wr;
         end else begin
            if (state == S_FIN) done_q <= 1'b1;
            if (timeout_hit) begin
               err_q  <= 1'b1;
               done_q <= 1'b0;
            end
         end
      end
   end

   // Read port with latency 1, returning pre-edge register contents
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= '0;
      end else if (s_read) begin
         case (s_address)
            2'd0:    readdata_q <= {12'd0, fmc_q, sel_q, ma_q};
            2'd1:    readdata_q <= {14'd0, rh_q};
            2'd2:    readdata_q <= {14'd0, lh_q};
            default: readdata_q <= {27'd0, ie_q, 1'b0, done_q, err_q, busy};
         endcase
      end
   end

   assign s_readdata        = readdata_q;
   assign irq               = ie_q && (done_q || err_q);
   assign membus_ma         = ma_q;
   assign membus_sel        = sel_q;
   assign membus_fmc_select = fmc_q;
   assign membus_mb_write   = {lh_q, rh_q};

endmodule
`default_nettype wire
